// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one instruction-fetch slot and one load/store slot onto a byte-wide RAM.
// Each request is split into 1/2/4 byte accesses. Read bytes are assembled little-endian and
// each completion is reported with a one-cycle OutEn pulse. Data requests win over fetches.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    // instruction-fetch requester
    input  logic        instEn,
    input  logic [31:0] instAddr,
    output logic        memInstFree,
    output logic        memInstOutEn,
    output logic [31:0] memInst,
    // load/store requester
    input  logic        dataEn,
    input  logic        dataWr,
    input  logic [31:0] dataAddr,
    input  logic [1:0]  dataLen,
    input  logic [31:0] dataIn,
    output logic        memDataFree,
    output logic        memDataOutEn,
    output logic [31:0] memDataOut,
    // RAM port
    output logic [31:0] ramAddr,
    output logic        ramWr,
    output logic [7:0]  ramDout,
    input  logic [7:0]  ramDin
);

    typedef enum logic [1:0] {StIdle, StInst, StDrd, StDwr} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;

    logic        inst_free_q, inst_free_d;
    logic [31:0] inst_addr_q, inst_addr_d;

    logic        data_free_q, data_free_d;
    logic        data_wr_q, data_wr_d;
    logic [31:0] data_addr_q, data_addr_d;
    logic [1:0]  data_len_q, data_len_d;
    logic [31:0] data_in_q, data_in_d;

    logic        inst_out_en_q, inst_out_en_d;
    logic [31:0] inst_word_q, inst_word_d;
    logic        data_out_en_q, data_out_en_d;
    logic [31:0] data_word_q, data_word_d;

    logic        inst_take, data_take;
    logic        inst_req, data_req, eff_wr;
    logic [1:0]  data_last;
    logic [31:0] asm_word;
    logic [31:0] base_addr;

    // Request slot capture, arbitration and byte sequencing.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        word_d        = word_q;
        inst_free_d   = inst_free_q;
        inst_addr_d   = inst_addr_q;
        data_free_d   = data_free_q;
        data_wr_d     = data_wr_q;
        data_addr_d   = data_addr_q;
        data_len_d    = data_len_q;
        data_in_d     = data_in_q;
        inst_out_en_d = 1'b0;
        inst_word_d   = inst_word_q;
        data_out_en_d = 1'b0;
        data_word_d   = data_word_q;

        // A strobe is only accepted into an empty slot.
        inst_take = instEn & inst_free_q;
        data_take = dataEn & data_free_q;
        if (inst_take) begin
            inst_free_d = 1'b0;
            inst_addr_d = instAddr;
        end
        if (data_take) begin
            data_free_d = 1'b0;
            data_wr_d   = dataWr;
            data_addr_d = dataAddr;
            data_len_d  = dataLen;
            data_in_d   = dataIn;
        end

        // In IDLE a cleared Free flag means a latched request is waiting.
        inst_req = inst_take | ~inst_free_q;
        data_req = data_take | ~data_free_q;
        eff_wr   = data_free_q ? dataWr : data_wr_q;

        // Current word with this cycle's RAM byte merged into lane cnt_q.
        asm_word = word_q;
        asm_word[{cnt_q, 3'b000} +: 8] = ramDin;

        unique case (state_q)
            StIdle: begin
                cnt_d  = 2'd0;
                word_d = 32'h0;
                if (data_req) begin
                    state_d = eff_wr ? StDwr : StDrd;
                end else if (inst_req) begin
                    state_d = StInst;
                end
            end
            StInst: begin
                word_d = asm_word;
                if (cnt_q == 2'd3) begin
                    inst_out_en_d = 1'b1;
                    inst_word_d   = asm_word;
                    inst_free_d   = 1'b1;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StDrd: begin
                word_d = asm_word;
                if (cnt_q == data_last) begin
                    data_out_en_d = 1'b1;
                    data_word_d   = asm_word;
                    data_free_d   = 1'b1;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            StDwr: begin
                if (cnt_q == data_last) begin
                    data_out_en_d = 1'b1;
                    data_free_d   = 1'b1;
                    state_d       = StIdle;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Index of the final byte of the latched data access; encoding 10 is a full word.
    always_comb begin
        unique case (data_len_q)
            2'b00:   data_last = 2'd0;
            2'b01:   data_last = 2'd1;
            default: data_last = 2'd3;
        endcase
    end

    // RAM port drive; idle values are all zero.
    always_comb begin
        base_addr = (state_q == StInst) ? inst_addr_q : data_addr_q;
        ramAddr   = 32'h0;
        ramWr     = 1'b0;
        ramDout   = 8'h0;
        if (state_q != StIdle) begin
            ramAddr = base_addr + {30'h0, cnt_q};
        end
        if (state_q == StDwr) begin
            ramWr   = 1'b1;
            ramDout = data_in_q[{cnt_q, 3'b000} +: 8];
        end
    end

    // State and slot registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= 2'd0;
            word_q        <= 32'h0;
            inst_free_q   <= 1'b1;
            inst_addr_q   <= 32'h0;
            data_free_q   <= 1'b1;
            data_wr_q     <= 1'b0;
            data_addr_q   <= 32'h0;
            data_len_q    <= 2'b00;
            data_in_q     <= 32'h0;
            inst_out_en_q <= 1'b0;
            inst_word_q   <= 32'h0;
            data_out_en_q <= 1'b0;
            data_word_q   <= 32'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            word_q        <= word_d;
            inst_free_q   <= inst_free_d;
            inst_addr_q   <= inst_addr_d;
            data_free_q   <= data_free_d;
            data_wr_q     <= data_wr_d;
            data_addr_q   <= data_addr_d;
            data_len_q    <= data_len_d;
            data_in_q     <= data_in_d;
            inst_out_en_q <= inst_out_en_d;
            inst_word_q   <= inst_word_d;
            data_out_en_q <= data_out_en_d;
            data_word_q   <= data_word_d;
        end
    end

    assign memInstFree  = inst_free_q;
    assign memInstOutEn = inst_out_en_q;
    assign memInst      = inst_word_q;
    assign memDataFree  = data_free_q;
    assign memDataOutEn = data_out_en_q;
    assign memDataOut   = data_word_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that sits between the single byte-wide RAM port and the two CPU-side requesters. It is the responder for the instruction-fetch request interface (`instEn`/`instAddr` in; `memInstFree`/`memInstOutEn`/`memInst` out) and for the load/store data interface. It serialises each 1/2/4-byte request into byte accesses, assembles read words little-endian, and returns a one-cycle completion pulse. Data requests have priority over instruction requests.

## Interface
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `instEn` in 1: fetch request strobe. One cycle; honoured only while `memInstFree`=1.
- `instAddr` in 32: fetch byte address, sampled with `instEn`.
- `memInstFree` out 1: no fetch pending or in service.
- `memInstOutEn` out 1: one-cycle pulse; `memInst` valid.
- `memInst` out 32: fetched word, little-endian.
- `dataEn` in 1: load/store request strobe. One cycle; honoured only while `memDataFree`=1.
- `dataWr` in 1: 1 = store, 0 = load.
- `dataAddr` in 32: data byte address.
- `dataLen` in 2: access size. 00 = 1 byte, 01 = 2 bytes, 11 = 4 bytes; 10 is treated as 4 bytes.
- `dataIn` in 32: store data. Byte i is bits [8i+7:8i].
- `memDataFree` out 1: no data request pending or in service.
- `memDataOutEn` out 1: one-cycle pulse; load data valid, or store complete.
- `memDataOut` out 32: load result, zero-extended.
- `ramAddr` out 32: RAM byte address.
- `ramWr` out 1: RAM write enable.
- `ramDout` out 8: RAM write byte.
- `ramDin` in 8: RAM read byte. Valid one cycle after the address was presented with `ramWr`=0.

## Operation
- **Pending slots.** There is one instruction slot and one data slot.
  - `instEn` while `memInstFree`=1 latches `instAddr` and clears `memInstFree`.
  - `dataEn` while `memDataFree`=1 latches `dataWr`, `dataAddr`, `dataLen` and `dataIn`, and clears `memDataFree`.
  - A strobe while the matching Free signal is 0 is ignored.
- **States:** IDLE, INST, DRD, DWR.
- **Arbitration in IDLE.** Each edge considers latched pending requests OR same-cycle strobes.
  - Data wins: go to DRD or DWR per `dataWr`.
  - Otherwise an instruction request goes to INST.
  - Otherwise stay in IDLE.
  - A strobe arriving in IDLE starts service at that same edge.
- **Byte counter.** N = access size in bytes (4 for INST). The counter steps 0..N-1. Address i = base + i, modulo 2^32; misaligned and wrapping addresses are legal.
- **INST / DRD:**
  - Present `ramAddr` = base + i, `ramWr`=0, for N consecutive cycles.
  - Capture `ramDin` into byte i one cycle later.
  - On the edge capturing byte N-1: assert the matching OutEn with the assembled word, set the matching Free to 1, go to IDLE.
- **DWR:**
  - Present `ramAddr` = base + i, `ramWr`=1, `ramDout` = `dataIn` byte i, for N consecutive cycles.
  - On the edge after the last byte: `memDataOutEn`=1, `memDataFree`=1, go to IDLE.
  - `memDataOut` holds its previous value after a store.
- **Outside active access cycles:** `ramAddr`=0, `ramWr`=0, `ramDout`=0.
- **Reset (including mid-transfer):**
  - All outputs go to 0, except `memInstFree` and `memDataFree`, which go to 1.
  - State goes to IDLE; pending slots are cleared.
  - A partial transfer is abandoned with no OutEn pulse and no further RAM writes.

## Timing
- E0 = the edge at which a request enters service.
- **Fetch:** addresses for bytes 0..3 are presented in the cycles after E0..E3. Bytes are captured at E1..E4. `memInstOutEn` is high for the cycle following E4. Latency from strobe edge to pulse is 4 cycles when IDLE.
- **Load of N bytes:** `memDataOutEn` follows E(N). Latency is N cycles.
- **Store of N bytes:** write cycles follow E0..E(N-1). `memDataOutEn` follows E(N).
- **After a completion edge:** the controller spends at least one cycle in IDLE (no RAM access) before the next service starts.
- **Same-cycle events:**
  - Both strobes in IDLE: data serviced first. The instruction request starts the cycle after the data completion's IDLE cycle.
  - A new request arriving during service is latched and waits.
- **OutEn pulses:** exactly one cycle each. `memInst` and `memDataOut` hold their values until the next completion of the same kind.

## Test plan
- **Single fetch.** After reset, RAM[0x100..0x103] = 13,05,00,00; pulse `instEn` with addr 0x100. Required: `memInstOutEn` 4 cycles later, `memInst`=0x00000513, `memInstFree` low in between.
- **Priority.** `instEn`(0x0) and `dataEn` load word (0x200) in the same cycle. Required: addresses 0x200..0x203 precede 0x0..0x3; `memDataOutEn` precedes `memInstOutEn`.
- **Half store.** `dataLen`=01, addr 0x301, `dataIn`=0xAABBCCDD. Required: writes CC to 0x302 and DD to 0x301 only, with `ramWr` high for exactly 2 cycles; then `memDataOutEn` pulse.
- **Byte load.** Load byte at 0x40 where RAM holds 0x80. Required: `memDataOut`=0x00000080.
- **Wrap-around.** Fetch at 0xFFFFFFFE. Required: addresses FFFFFFFE, FFFFFFFF, 0, 1 in that order.
- **Reset mid-store.** Assert `rst` during byte 2 of a word store. Required: `ramWr`=0 immediately, no `memDataOutEn`, both Free signals =1, and the next fetch works normally.
